// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store, with sub-word store read-modify-write.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic              if_err_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [1:0]        d_size_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_done_o,
  output logic              d_err_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] RD_REQ      = 3'd1;
  localparam logic [2:0] RD_WAIT     = 3'd2;
  localparam logic [2:0] WR_REQ      = 3'd3;
  localparam logic [2:0] RMW_RD_REQ  = 3'd4;
  localparam logic [2:0] RMW_RD_WAIT = 3'd5;
  localparam logic [2:0] RMW_WR_REQ  = 3'd6;
  localparam logic [2:0] ERR         = 3'd7;
  logic [2:0]        state_q, state_d;
  logic              own_d_q, own_d_d;
  logic              last_d_q, last_d_d;
  logic [1:0]        off_q, off_d;
  logic              half_q, half_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              grant_d, d_mis, if_mis;
  logic              rd_fin, wr_fin, err_fin, fin;
  logic [DATA_W-1:0] merged;
  // round-robin: on a tie, the requester not granted last wins
  assign grant_d = d_req_i & (~if_req_i | ~last_d_q);
  assign d_mis   = (d_size_i == 2'b11) | ((d_size_i == 2'b01) & d_addr_i[0]) |
                   ((d_size_i == 2'b10) & |d_addr_i[1:0]);
  assign if_mis  = |if_addr_i[1:0];
  always_comb begin
    merged = mem_rdata_i;
    if (half_q) merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
    else merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
  end
  always_comb begin
    state_d     = state_q;
    own_d_d     = own_d_q;
    last_d_d    = last_d_q;
    off_d       = off_q;
    half_d      = half_q;
    wdata_d     = wdata_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (if_req_i | d_req_i) begin
          own_d_d  = grant_d;
          last_d_d = grant_d;
          mem_we_d = 1'b0;
          if (grant_d) begin
            off_d      = d_addr_i[1:0];
            half_d     = d_size_i[0];
            wdata_d    = d_wdata_i[15:0];
            mem_addr_d = {d_addr_i[ADDR_W-1:2], 2'b00};
            if (d_mis) state_d = ERR;
            else if (!d_we_i) state_d = RD_REQ;
            else if (d_size_i == 2'b10) begin
              state_d     = WR_REQ;
              mem_we_d    = 1'b1;
              mem_wdata_d = d_wdata_i;
            end else state_d = RMW_RD_REQ;
          end else begin
            off_d      = 2'b00;
            mem_addr_d = {if_addr_i[ADDR_W-1:2], 2'b00};
            state_d    = if_mis ? ERR : RD_REQ;
          end
        end
      end
      RD_REQ:      state_d = mem_ready_i ? RD_WAIT : RD_REQ;
      RD_WAIT:     state_d = mem_rvalid_i ? IDLE : RD_WAIT;
      WR_REQ: begin
        state_d  = mem_ready_i ? IDLE : WR_REQ;
        mem_we_d = ~mem_ready_i;
      end
      RMW_RD_REQ:  state_d = mem_ready_i ? RMW_RD_WAIT : RMW_RD_REQ;
      RMW_RD_WAIT: begin
        if (mem_rvalid_i) begin
          state_d     = RMW_WR_REQ;
          mem_we_d    = 1'b1;
          mem_wdata_d = merged;
        end
      end
      RMW_WR_REQ: begin
        state_d  = mem_ready_i ? IDLE : RMW_WR_REQ;
        mem_we_d = ~mem_ready_i;
      end
      default:     state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      own_d_q     <= 1'b0;
      last_d_q    <= 1'b0;
      off_q       <= 2'b00;
      half_q      <= 1'b0;
      wdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      own_d_q     <= own_d_d;
      last_d_q    <= last_d_d;
      off_q       <= off_d;
      half_q      <= half_d;
      wdata_q     <= wdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
  assign mem_req_o   = state_q inside {RD_REQ, WR_REQ, RMW_RD_REQ, RMW_WR_REQ};
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rd_fin  = (state_q == RD_WAIT) & mem_rvalid_i;
  assign wr_fin  = ((state_q == WR_REQ) | (state_q == RMW_WR_REQ)) & mem_ready_i;
  assign err_fin = state_q == ERR;
  assign fin     = rd_fin | wr_fin | err_fin;
  assign if_done_o  = fin & ~own_d_q;
  assign d_done_o   = fin & own_d_q;
  assign if_err_o   = err_fin & ~own_d_q;
  assign d_err_o    = err_fin & own_d_q;
  assign if_rdata_o = (rd_fin & ~own_d_q) ? mem_rdata_i : '0;
  assign d_rdata_o  = (rd_fin & own_d_q) ? (mem_rdata_i >> {off_q, 3'b000}) : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter with a one-cycle-latency memory responder.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req, if_done, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_done, d_err;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_done_o(if_done), .if_err_o(if_err), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_size_i(d_size), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_done_o(d_done), .d_err_o(d_err), .d_rdata_o(d_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ready_i(mem_ready), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );
  typedef struct packed {logic d; logic err; logic [31:0] rdata;} exp_t;
  exp_t        sb[$];
  exp_t        e_m;
  int          tests = 0, fails = 0;
  logic [31:0] mem [0:1023];
  logic        rv_q, rv_en, poke_en;
  logic [31:0] rd_q, poke_a, poke_d, acc_addr;
  logic        acc_we;
  int          reqcnt = 0, wrcnt = 0;
  int          n1, n2, w0, r0;
  assign mem_rvalid = rv_q & rv_en;
  assign mem_rdata  = rd_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q <= 1'b0;
      rd_q <= '0;
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else begin
      rv_q <= mem_req && mem_ready && !mem_we;
      rd_q <= mem[mem_addr[11:2]];
      if (mem_req) reqcnt <= reqcnt + 1;
      if (mem_req && mem_ready) begin
        acc_addr <= mem_addr;
        acc_we   <= mem_we;
      end
      if (mem_req && mem_ready && mem_we) begin
        mem[mem_addr[11:2]] <= mem_wdata;
        wrcnt <= wrcnt + 1;
      end
      if (poke_en) mem[poke_a[11:2]] <= poke_d;
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && (if_done || d_done)) begin
      check("done_exclusive", {31'b0, if_done & d_done}, 32'd0);
      if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        e_m = sb.pop_front();
        check("done_owner", {31'b0, d_done}, {31'b0, e_m.d});
        check("done_err", {31'b0, e_m.d ? d_err : if_err}, {31'b0, e_m.err});
        check("done_rdata", e_m.d ? d_rdata : if_rdata, e_m.rdata);
      end
    end
  end
  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    poke_a = a;
    poke_d = d;
    poke_en = 1'b1;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask
  task automatic req_if(input logic [31:0] a, output int n);
    @(posedge clk);
    #1 if_addr = a;
    if_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_done && n < 200);
    if (!if_done) check("if_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 if_req = 1'b0;
  endtask
  task automatic req_d(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd, output int n);
    @(posedge clk);
    #1 d_we = we;
    d_size = sz;
    d_addr = a;
    d_wdata = wd;
    d_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_done && n < 200);
    if (!d_done) check("d_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 d_req = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout after %0d tests", tests);
    $fatal(1, "timeout");
  end
  initial begin
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 1; rv_en = 1; poke_en = 0; poke_a = 0; poke_d = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_done", {30'b0, if_done, d_done}, 32'd0);
    check("rst_rdata", if_rdata | d_rdata, 32'd0);
    rst_n = 1;
    poke(32'h100, 32'h00000013);
    sb.push_back('{d: 1'b0, err: 1'b0, rdata: 32'h00000013});
    req_if(32'h100, n1);
    check("t1_latency", n1, 32'd3);
    check("t1_mem_addr", acc_addr, 32'h100);
    check("t1_mem_we", {31'b0, acc_we}, 32'd0);
    poke(32'h200, 32'h55667788);
    poke(32'h104, 32'hCAFE0001);
    for (int r = 0; r < 2; r++) begin
      sb.push_back('{d: 1'b1, err: 1'b0, rdata: 32'h55667788});
      sb.push_back('{d: 1'b0, err: 1'b0, rdata: 32'hCAFE0001});
      fork
        req_if(32'h104, n1);
        req_d(1'b0, 2'b10, 32'h200, 32'h0, n2);
      join
      check("t2_d_latency", n2, 32'd3);
      check("t2_if_latency", n1, 32'd6);
    end
    poke(32'h200, 32'h11223344);
    w0 = wrcnt;
    sb.push_back('{d: 1'b1, err: 1'b0, rdata: 32'h0});
    req_d(1'b1, 2'b00, 32'h203, 32'h000000AB, n2);
    check("t3_latency", n2, 32'd4);
    check("t3_writes", wrcnt, w0 + 1);
    check("t3_wr_addr", acc_addr, 32'h200);
    check("t3_mem", mem[32'h200 >> 2], 32'hAB223344);
    poke(32'h200, 32'hBEEF1234);
    sb.push_back('{d: 1'b1, err: 1'b0, rdata: 32'h0000BEEF});
    req_d(1'b0, 2'b01, 32'h202, 32'h0, n2);
    r0 = reqcnt;
    sb.push_back('{d: 1'b1, err: 1'b1, rdata: 32'h0});
    req_d(1'b1, 2'b01, 32'h201, 32'h5555, n2);
    check("t4_err_latency", n2, 32'd2);
    check("t4_no_mem_req", reqcnt, r0);
    sb.push_back('{d: 1'b1, err: 1'b0, rdata: 32'h0});
    req_d(1'b1, 2'b01, 32'h202, 32'h12347777, n2);
    check("t4_sh_mem", mem[32'h200 >> 2], 32'h77771234);
    sb.push_back('{d: 1'b1, err: 1'b0, rdata: 32'h00777712});
    req_d(1'b0, 2'b00, 32'h201, 32'h0, n2);
    sb.push_back('{d: 1'b1, err: 1'b1, rdata: 32'h0});
    req_d(1'b0, 2'b11, 32'h200, 32'h0, n2);
    sb.push_back('{d: 1'b0, err: 1'b1, rdata: 32'h0});
    req_if(32'h102, n1);
    check("t4_if_err_latency", n1, 32'd2);
    mem_ready = 0;
    sb.push_back('{d: 1'b1, err: 1'b0, rdata: 32'h0});
    fork
      req_d(1'b1, 2'b10, 32'h300, 32'hDEADBEEF, n2);
      begin
        @(posedge clk);
        #1;
        @(negedge clk);
        repeat (5) begin
          @(negedge clk);
          check("t5_stall_req", {31'b0, mem_req}, 32'd1);
          check("t5_stall_we", {31'b0, mem_we}, 32'd1);
          check("t5_stall_addr", mem_addr, 32'h300);
          check("t5_stall_wdata", mem_wdata, 32'hDEADBEEF);
          check("t5_stall_done", {31'b0, d_done}, 32'd0);
        end
        @(posedge clk);
        #1 mem_ready = 1;
      end
    join
    check("t5_latency", n2, 32'd7);
    check("t5_mem", mem[32'h300 >> 2], 32'hDEADBEEF);
    poke(32'h200, 32'h11223344);
    w0 = wrcnt;
    rv_en = 0;
    @(posedge clk);
    #1 d_we = 1; d_size = 2'b00; d_addr = 32'h200; d_wdata = 32'hAB; d_req = 1;
    repeat (4) @(negedge clk);
    check("t6_in_wait", {31'b0, mem_req}, 32'd0);
    rst_n = 0;
    #1;
    check("t6_rst_req", {31'b0, mem_req}, 32'd0);
    check("t6_rst_done", {31'b0, d_done}, 32'd0);
    check("t6_rst_addr", mem_addr, 32'd0);
    d_req = 0;
    @(posedge clk);
    #1;
    check("t6_no_write", wrcnt, w0);
    rst_n = 1;
    rv_en = 1;
    poke(32'h100, 32'h00500093);
    sb.push_back('{d: 1'b0, err: 1'b0, rdata: 32'h00500093});
    req_if(32'h100, n1);
    check("t6_fetch_latency", n1, 32'd3);
    repeat (2) @(posedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-ported data/instruction memory between the instruction-fetch requester and the load/store requester of the multi-cycle core. Each access is sequenced as a memory-side request/ready/rvalid transaction with one transaction outstanding. Sub-word stores (sb/sh) are performed as an internal read-modify-write of the containing word, and misaligned accesses are rejected. Load sign/zero extension stays in the core controller; this block returns the addressed bytes right-aligned.

Parameters:
ADDR_W, 32, byte-address width of requesters and memory port
DATA_W, 32, data width (fixed at 32; other values unsupported)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held with if_addr stable until if_done
if_addr  in  ADDR_W  fetch byte address
if_done  out  1  fetch complete (data valid or error), one-cycle pulse
if_err  out  1  valid with if_done: misaligned fetch
if_rdata  out  32  fetched word, valid with if_done & !if_err, else 0
d_req  in  1  data request; attributes held stable until d_done
d_we  in  1  1=store, 0=load
d_size  in  2  00 byte, 01 half, 10 word, 11 reserved
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  store data, right-aligned
d_done  out  1  data access complete, one-cycle pulse
d_err  out  1  valid with d_done: misaligned or reserved size
d_rdata  out  32  load data = mem word >> (8*d_addr[1:0]), valid with load d_done, else 0
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  memory write
mem_addr  out  ADDR_W  word address, bits [1:0] always 0
mem_wdata  out  32  write word
mem_ready  in  1  memory accepts request this cycle when mem_req=1
mem_rvalid  in  1  read data valid; earliest one cycle after acceptance
mem_rdata  in  32  read word

Behaviour:
- Reset (async, rst_n=0): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all done/err=0, rdata=0, rr pointer = "last granted IF". In-flight transaction is dropped, no done issued; memory is reset alongside.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, RMW_RD_REQ, RMW_RD_WAIT, RMW_WR_REQ, ERR.
- IDLE: arbitrates. Only one requesting → grant it. Both requesting → round-robin: grant whichever was not granted last. The winner's attributes and owner are registered at the edge; the loser keeps waiting.
- Alignment: fetch requires addr[1:0]=0. Half requires addr[0]=0. Word requires addr[1:0]=0. d_size=11 is an error. Error → ERR for one cycle: owner done=1, err=1, no memory access.
- Fetch or load → RD_REQ (mem_req=1, mem_we=0) until mem_ready → RD_WAIT. On mem_rvalid: owner done=1 combinationally, rdata driven, → IDLE.
- Word store → WR_REQ (mem_we=1, mem_wdata=d_wdata) until mem_ready. Done pulses in the mem_ready cycle, → IDLE.
- Byte/half store → RMW_RD_REQ → RMW_RD_WAIT. On mem_rvalid, merge into the captured word: byte lane off=addr[1:0] replaced by wdata[7:0]; half lanes off, off+1 replaced by wdata[15:0]. Then → RMW_WR_REQ, write the merged word, done on mem_ready, → IDLE.
- mem_req is low in IDLE and ERR. mem_addr/mem_we/mem_wdata are stable while mem_req=1 and stalled on mem_ready=0.
- Minimum latency from req to done: read 3 cycles (IDLE, RD_REQ, RD_WAIT with rvalid); word store 2; sub-word store 4; error 2.
- Requesters drop req at the edge where done is sampled. A req still high in the following IDLE cycle is a new request.
- mem_rvalid outside a WAIT state is ignored. mem_ready outside a REQ state is ignored.
- The done pulse of one requester never coincides with the done pulse of the other.

Test Plan:
1. Fetch if_addr=0x100, mem_ready=1, rvalid 1 cycle later with 0x00000013 → if_done on 3rd cycle, if_rdata=0x00000013, mem_addr=0x100, mem_we=0.
2. if_req and d_req (lw 0x200) asserted together from reset, both held → data served first, then fetch; with repeated simultaneous requests, grants alternate D, IF, D, IF.
3. sb d_addr=0x203, d_wdata=0xAB, memory word 0x11223344 → read then write of 0xAB223344 to 0x200, single d_done, d_err=0.
4. lh d_addr=0x202, memory 0xBEEF1234 → d_rdata=0x0000BEEF. sh at 0x201 → d_done & d_err after 2 cycles, mem_req never asserted.
5. mem_ready held 0 for 5 cycles during sw 0x300=0xDEADBEEF → mem_req/addr/wdata stable throughout, d_done in the cycle mem_ready rises.
6. rst_n pulled low in RMW_RD_WAIT → mem_req=0 immediately, no write issued, no d_done; after release, new fetch completes normally.
